// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring divide,
// one bit per cycle, with divide special cases resolved at acceptance.
module muldiv_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [31:0] instruction,
   input  logic [31:0] rs1_val,
   input  logic [31:0] rs2_val,
   input  logic        kill,
   output logic        req_ready,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   localparam logic [6:0] OpcodeOp     = 7'b0110011;
   localparam logic [6:0] Funct7Muldiv = 7'b0000001;

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

   state_e      state_q, state_d;
   logic [5:0]  count_q;
   logic [63:0] acc_q;
   logic [31:0] operand_q;
   logic [2:0]  f3_q;
   logic        neg1_q, neg2_q;
   logic [31:0] result_q;

   // Request decode
   logic [2:0]  funct3;
   logic        is_m, is_div, accept;
   logic        rs1_signed, rs2_signed, s1_neg, s2_neg;
   logic [31:0] mag1, mag2;
   logic        div_zero, div_ovf, special;
   logic [31:0] special_res;

   assign funct3     = instruction[14:12];
   assign is_m       = (instruction[6:0] == OpcodeOp) && (instruction[31:25] == Funct7Muldiv);
   assign is_div     = funct3[2];
   assign accept     = req_valid && req_ready && is_m && !kill;
   assign rs1_signed = is_div ? !funct3[0] : (funct3 != 3'b011);
   assign rs2_signed = is_div ? !funct3[0] : !funct3[1];
   assign s1_neg     = rs1_signed && rs1_val[31];
   assign s2_neg     = rs2_signed && rs2_val[31];
   assign mag1       = s1_neg ? (32'd0 - rs1_val) : rs1_val;
   assign mag2       = s2_neg ? (32'd0 - rs2_val) : rs2_val;
   assign div_zero   = (rs2_val == 32'd0);
   assign div_ovf    = !funct3[0] && (rs1_val == 32'h8000_0000) && (rs2_val == 32'hFFFF_FFFF);
   assign special    = is_div && (div_zero || div_ovf);
   assign special_res = funct3[1] ? (div_zero ? rs1_val : 32'd0)
                                  : (div_zero ? 32'hFFFF_FFFF : 32'h8000_0000);

   // One iteration step; acc_q holds {partial, multiplier} or {remainder, quotient}
   logic [32:0] mul_sum, div_shift, div_diff;
   logic        div_ge;
   logic [63:0] mul_next, div_next, step_next;

   assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, operand_q} : 33'd0);
   assign mul_next  = {mul_sum, acc_q[31:1]};
   assign div_shift = {acc_q[63:32], acc_q[31]};
   assign div_ge    = (div_shift >= {1'b0, operand_q});
   assign div_diff  = div_shift - {1'b0, operand_q};
   assign div_next  = {(div_ge ? div_diff[31:0] : div_shift[31:0]), acc_q[30:0], div_ge};
   assign step_next = f3_q[2] ? div_next : mul_next;

   logic [63:0] prod_s;
   logic [31:0] quot_s, rem_s, final_res;

   always_comb begin
      prod_s = (neg1_q ^ neg2_q) ? (64'd0 - step_next) : step_next;
      quot_s = (neg1_q ^ neg2_q) ? (32'd0 - step_next[31:0]) : step_next[31:0];
      rem_s  = neg1_q ? (32'd0 - step_next[63:32]) : step_next[63:32];
      if (!f3_q[2]) begin
         final_res = (f3_q[1:0] == 2'b00) ? prod_s[31:0] : prod_s[63:32];
      end else begin
         final_res = f3_q[1] ? rem_s : quot_s;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = !is_div ? StMul : (special ? StDone : StDiv);
            end
         end
         StMul, StDiv: begin
            if (count_q == 6'd31) state_d = StDone;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (kill) state_d = StIdle;
   end

   always_comb begin
      req_ready = (state_q == StIdle);
      busy      = (state_q != StIdle);
      done      = (state_q == StDone);
   end

   // Kill freezes the datapath so result keeps its last reported value
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q   <= 6'd0;
         acc_q     <= 64'd0;
         operand_q <= 32'd0;
         f3_q      <= 3'd0;
         neg1_q    <= 1'b0;
         neg2_q    <= 1'b0;
         result_q  <= 32'd0;
      end else if (!kill) begin
         if (accept) begin
            count_q   <= 6'd0;
            acc_q     <= {32'd0, (is_div ? mag1 : mag2)};
            operand_q <= is_div ? mag2 : mag1;
            f3_q      <= funct3;
            neg1_q    <= s1_neg;
            neg2_q    <= s2_neg;
            if (special) result_q <= special_res;
         end else if ((state_q == StMul) || (state_q == StDiv)) begin
            acc_q   <= step_next;
            count_q <= count_q + 6'd1;
            if (count_q == 6'd31) result_q <= final_res;
         end
      end
   end

   assign result = result_q;

   logic unused_bits;
   assign unused_bits = ^{instruction[24:15], instruction[11:7], div_diff[32]};

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, results, special cases, kill and async reset.
module tb_muldiv_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic [31:0] instruction;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic        kill;
   logic        req_ready;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   muldiv_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .instruction (instruction),
      .rs1_val     (rs1_val),
      .rs2_val     (rs2_val),
      .kill        (kill),
      .req_ready   (req_ready),
      .busy        (busy),
      .done        (done),
      .result      (result)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] m_insn(input logic [2:0] f3);
      return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
   endfunction

   // Issue one request, scramble inputs after acceptance, then time the done pulse
   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      int lat;
      int busy_cnt;
      @(negedge clk);
      req_valid   = 1'b1;
      instruction = m_insn(f3);
      rs1_val     = a;
      rs2_val     = b;
      @(posedge clk);
      #1;
      req_valid   = 1'b0;
      rs1_val     = 32'hDEAD_BEEF;
      rs2_val     = 32'h0BAD_F00D;
      instruction = m_insn(~f3);
      lat = 0;
      busy_cnt = 0;
      while (done !== 1'b1 && lat < 100) begin
         if (busy === 1'b1) busy_cnt++;
         @(posedge clk);
         #1;
         lat++;
      end
      if (busy === 1'b1) busy_cnt++;
      check_eq({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check_eq({tag, " result"}, {32'd0, result}, {32'd0, exp});
      check_eq({tag, " busy cycles"}, 64'(busy_cnt), 64'(exp_lat + 1));
      @(posedge clk);
      #1;
      check_eq({tag, " back to idle"}, {61'd0, busy, done, req_ready}, 64'b001);
   endtask

   initial begin
      rst         = 1'b1;
      req_valid   = 1'b0;
      kill        = 1'b0;
      instruction = 32'd0;
      rs1_val     = 32'd0;
      rs2_val     = 32'd0;
      #12;
      check_eq("reset outputs", {61'd0, busy, done, req_ready}, 64'b001);
      check_eq("reset result", {32'd0, result}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op("MUL 7*-6",        3'b000, 32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFD6, 32);
      run_op("MULH min*min",    3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32);
      run_op("MULHU min*min",   3'b011, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32);
      run_op("MULHSU -1*2",     3'b010, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 32);
      run_op("MULHU max*max",   3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32);
      run_op("MUL -1*-1",       3'b000, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,         32);
      run_op("DIV -7/2",        3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 32);
      run_op("REM -7/2",        3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32);
      run_op("DIV 7/-2",        3'b100, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32);
      run_op("REM 7/-2",        3'b110, 32'd7,          32'hFFFF_FFFE, 32'd1,         32);
      run_op("DIVU 100/7",      3'b101, 32'd100,        32'd7,         32'd14,        32);
      run_op("REMU 100/7",      3'b111, 32'd100,        32'd7,         32'd2,         32);
      run_op("DIVU 5/0",        3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 0);
      run_op("REM 5/0",         3'b110, 32'd5,          32'd0,         32'd5,         0);
      run_op("DIV ovf",         3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0);
      run_op("REM ovf",         3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         0);
      run_op("REMU 100/7 again", 3'b111, 32'd100,       32'd7,         32'd2,         32);

      // Kill a divide at iteration 10
      @(negedge clk);
      req_valid   = 1'b1;
      instruction = m_insn(3'b101);
      rs1_val     = 32'd1000;
      rs2_val     = 32'd3;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check_eq("kill pre busy", {63'd0, busy}, 64'd1);
      @(negedge clk);
      kill = 1'b1;
      @(posedge clk);
      #1;
      kill = 1'b0;
      check_eq("kill to idle", {61'd0, busy, done, req_ready}, 64'b001);
      check_eq("kill result held", {32'd0, result}, 64'd2);
      run_op("MUL 3*4 after kill", 3'b000, 32'd3, 32'd4, 32'd12, 32);

      // Kill beats a request in idle
      @(negedge clk);
      kill        = 1'b1;
      req_valid   = 1'b1;
      instruction = m_insn(3'b000);
      rs1_val     = 32'd9;
      rs2_val     = 32'd9;
      @(posedge clk);
      #1;
      kill      = 1'b0;
      req_valid = 1'b0;
      check_eq("kill wins in idle", {61'd0, busy, done, req_ready}, 64'b001);

      // Asynchronous reset between edges, mid-multiply
      @(negedge clk);
      req_valid   = 1'b1;
      instruction = m_insn(3'b000);
      rs1_val     = 32'd5;
      rs2_val     = 32'd5;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_eq("async rst outputs", {61'd0, busy, done, req_ready}, 64'b001);
      check_eq("async rst result", {32'd0, result}, 64'd0);
      @(negedge clk);
      rst         = 1'b0;
      req_valid   = 1'b1;
      instruction = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check_eq("non-M ignored", {61'd0, busy, done, req_ready}, 64'b001);
      run_op("MUL 6*7 after rst", 3'b000, 32'd6, 32'd7, 32'd42, 32);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
